// File: rtl/dsc_mul_seq.sv
// Sequencer for one dsc_mul core: accepts operand pairs, runs clear/enable/settle/capture,
// and returns the product with its RUN cycle count, a timeout flag and running statistics.
module dsc_mul_seq #(
    parameter int NUM_BITS   = 10,
    parameter int CNT_W      = 32,
    parameter int TIMEOUT    = 2**(2*NUM_BITS)+8,
    parameter int CLR_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [NUM_BITS-1:0]     req_a,
    input  logic [NUM_BITS-1:0]     req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [2*NUM_BITS-1:0]   rsp_z,
    output logic [CNT_W-1:0]        rsp_cycles,
    output logic                    rsp_err,
    output logic                    core_rst,
    output logic                    core_en,
    output logic [NUM_BITS-1:0]     core_a,
    output logic [NUM_BITS-1:0]     core_b,
    input  logic [2*NUM_BITS-1:0]   core_z,
    input  logic                    core_ov,
    output logic [15:0]             stat_ops,
    output logic [CNT_W+15:0]       stat_cyc_acc
);

    localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST    = CLR_W'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, HOLD, RESP} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [CLR_W-1:0]  clr_cnt;

    // cnt_inc already includes the RUN cycle being sampled, so ov and timeout see the same count
    assign cnt_inc = cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            clr_cnt      <= '0;
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_z        <= '0;
            rsp_cycles   <= '0;
            rsp_err      <= 1'b0;
            core_rst     <= 1'b1;
            core_en      <= 1'b0;
            core_a       <= '0;
            core_b       <= '0;
            stat_ops     <= '0;
            stat_cyc_acc <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        core_a    <= req_a;
                        core_b    <= req_b;
                        cnt       <= '0;
                        clr_cnt   <= '0;
                        req_ready <= 1'b0;
                        state     <= CLEAR;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_cnt == CLR_LAST) begin
                        core_rst <= 1'b0;
                        core_en  <= 1'b1;
                        state    <= RUN;
                    end else begin
                        clr_cnt <= clr_cnt + CLR_W'(1);
                    end
                end
                RUN: begin
                    cnt <= cnt_inc;
                    if (core_ov) begin
                        core_en    <= 1'b0;
                        rsp_cycles <= cnt_inc;
                        rsp_err    <= 1'b0;
                        state      <= HOLD;
                    end else if (cnt_inc == TIMEOUT_CNT) begin
                        core_en    <= 1'b0;
                        rsp_cycles <= cnt_inc;
                        rsp_err    <= 1'b1;
                        rsp_z      <= '0;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end
                end
                HOLD: begin
                    rsp_z     <= core_z;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    // Core stays out of reset here so its product remains observable until consumed
                    if (rsp_ready) begin
                        rsp_valid    <= 1'b0;
                        core_rst     <= 1'b1;
                        req_ready    <= 1'b1;
                        stat_cyc_acc <= stat_cyc_acc + {16'd0, rsp_cycles};
                        if (stat_ops != 16'hFFFF) begin
                            stat_ops <= stat_ops + 16'd1;
                        end
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
